// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event detector.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEATING
    } key_state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event_channel.sv
// One active-low key: synchroniser, debounce, press/release pulses and typematic repeat.
module key_event_channel
    import key_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DB_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W    = cnt_width(RPT_MAX);
    localparam int unsigned DB_TERM  = DEBOUNCE_CYCLES - 1;
    localparam int unsigned RD_TERM  = (REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1;
    localparam int unsigned RP_TERM  = REPEAT_PERIOD - 1;

    logic [1:0]      sync_q;
    logic            raw;
    logic [DB_W-1:0] db_cnt;
    logic            accept;
    logic            press_acc;
    logic            release_acc;

    key_state_t      state, state_nxt;
    logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
    logic            repeat_nxt;

    assign raw         = ~sync_q[1];
    assign accept      = (raw != level) && (db_cnt == DB_W'(DB_TERM));
    assign press_acc   = accept && raw;
    assign release_acc = accept && !raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '1;
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], key};
            press_pulse   <= press_acc;
            release_pulse <= release_acc;
            if (raw == level) begin
                db_cnt <= '0;
            end else if (accept) begin
                level  <= raw;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rpt_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            rpt_cnt      <= rpt_nxt;
            repeat_pulse <= repeat_nxt;
        end
    end

    // Release wins over a repeat that would fall due on the same edge.
    always_comb begin
        state_nxt  = state;
        rpt_nxt    = rpt_cnt;
        repeat_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (press_acc) begin
                    state_nxt = HELD;
                    rpt_nxt   = '0;
                end
            end
            HELD: begin
                if (release_acc) begin
                    state_nxt = IDLE;
                    rpt_nxt   = '0;
                end else if (REPEAT_DELAY != 0) begin
                    if (rpt_cnt == RPT_W'(RD_TERM)) begin
                        state_nxt  = REPEATING;
                        rpt_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
            end
            REPEATING: begin
                if (release_acc) begin
                    state_nxt = IDLE;
                    rpt_nxt   = '0;
                end else if (rpt_cnt == RPT_W'(RP_TERM)) begin
                    rpt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    rpt_nxt = rpt_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                rpt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_event_detector.sv
// NUM_KEYS independent key channels plus an any-key-held indication.
module key_event_detector
    import key_event_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] keyIsPressed,
    output logic [NUM_KEYS-1:0] pressPulse,
    output logic [NUM_KEYS-1:0] releasePulse,
    output logic [NUM_KEYS-1:0] repeatPulse,
    output logic                anyPressed
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_event_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .key          (key[i]),
            .level        (keyIsPressed[i]),
            .press_pulse  (pressPulse[i]),
            .release_pulse(releasePulse[i]),
            .repeat_pulse (repeatPulse[i])
        );
    end

    assign anyPressed = |keyIsPressed;

endmodule

// File: tb/tb_key_event_detector.sv
// Event scoreboard bench: a 4-key repeating build plus a 1-key build with auto-repeat disabled.
module tb_key_event_detector;

    localparam int NK  = 4;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DEB + 2;   // window of key change to window where pulse is seen

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] lvl, prs, rls, rpt;
    logic          any;
    logic [0:0]    key2 = 1'b1;
    logic [0:0]    lvl2, prs2, rls2, rpt2;
    logic          any2;

    key_event_detector #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .key(key), .keyIsPressed(lvl), .pressPulse(prs),
        .releasePulse(rls), .repeatPulse(rpt), .anyPressed(any)
    );

    key_event_detector #(
        .NUM_KEYS(1), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
    ) dut_norpt (
        .clk(clk), .reset(reset), .key(key2), .keyIsPressed(lvl2), .pressPulse(prs2),
        .releasePulse(rls2), .repeatPulse(rpt2), .anyPressed(any2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;    // 0..3 main build, 4 = no-repeat build
        int kind;  // 0 press, 1 release, 2 repeat
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] exp_level = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Press seen LAT windows after t_dn; release (if rel) at t_stop; repeats strictly before t_stop.
    task automatic expect_hold(input int ch, input int t_dn, input int t_stop, input bit rel);
        int p;
        p = t_dn + LAT;
        sb.push_back('{p, ch, 0});
        if (rel) sb.push_back('{t_stop, ch, 1});
        if (ch < NK) begin
            for (int r = p + RD; r < t_stop; r += RP) sb.push_back('{r, ch, 2});
        end
    endtask

    task automatic step(input int n);
        logic [4:0] ep, er, et;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) exp_level = '0;
            ep = '0; er = '0; et = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        0: ep[sb[i].ch] = 1'b1;
                        1: er[sb[i].ch] = 1'b1;
                        default: et[sb[i].ch] = 1'b1;
                    endcase
                    sb.delete(i);
                end
            end
            exp_level = (exp_level | ep) & ~er;
            check("press",   32'({prs2, prs}), 32'(ep));
            check("release", 32'({rls2, rls}), 32'(er));
            check("repeat",  32'({rpt2, rpt}), 32'(et));
            check("level",   32'({lvl2, lvl}), 32'(exp_level));
            check("any",     32'({any2, any}), 32'({exp_level[4], |exp_level[3:0]}));
        end
    endtask

    initial begin
        int t;
        int c;
        step(3);
        reset = 1'b0;
        step(5);

        // Clean press and hold 40, then release; final repeat collides with release.
        t = cyc;
        key[0] = 1'b0;
        expect_hold(0, t, t + 40 + LAT, 1);
        step(40);
        key[0] = 1'b1;
        step(15);

        // Bounce: 3 low, 2 high, then steady low for 30.
        t = cyc;
        key[1] = 1'b0;
        step(3);
        key[1] = 1'b1;
        step(2);
        key[1] = 1'b0;
        expect_hold(1, t + 5, t + 5 + 30 + LAT, 1);
        step(30);
        key[1] = 1'b1;
        step(15);

        // Simultaneous press of keys 2 and 3.
        t = cyc;
        key[3:2] = 2'b00;
        expect_hold(2, t, t + 30 + LAT, 1);
        expect_hold(3, t, t + 30 + LAT, 1);
        step(30);
        key[3:2] = 2'b11;
        step(15);

        // Reset for one clock while key 0 is auto-repeating.
        t = cyc;
        c = t + 40;
        key[0] = 1'b0;
        expect_hold(0, t, c + 1, 0);
        step(40);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_hold(0, c + 1, c + 1 + 30 + LAT, 1);
        step(30);
        key[0] = 1'b1;
        step(15);

        // Auto-repeat disabled build: hold 100.
        t = cyc;
        key2 = 1'b0;
        expect_hold(NK, t, t + 100 + LAT, 1);
        step(100);
        key2 = 1'b1;
        step(15);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
